// File: rtl/vending_machine_pkg.sv
// Shared encodings for the single-product vending controller.
// State/coin codes and the price constant used by vending_machine.
package vending_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] coin_t;

    // Credit states; 2'b11 is never entered in normal operation
    localparam state_t S0  = 2'b00;
    localparam state_t S5  = 2'b01;
    localparam state_t S10 = 2'b10;

    // Coin codes from the acceptor; 2'b11 is invalid and acts as no coin
    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_5    = 2'b01;
    localparam coin_t COIN_10   = 2'b10;

    // Product price in coin units; documents the vend threshold
    localparam int PRICE = 15;

endpackage

// File: rtl/vending_machine.sv
// Coin-accumulating vending FSM: vends at >= 15 units of credit.
// Ports: clk, reset (sync, active-high), coin[1:0], out (vend strobe),
// state/newstate (debug), change (only with VENDING_MACHINE_CHANGE_RETURN_EN).
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    output logic       out,
    output logic [1:0] state,
    output logic [1:0] newstate
`ifdef VENDING_MACHINE_CHANGE_RETURN_EN
    ,
    output logic       change
`endif
);

    logic chg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= newstate;
        end
    end

    // Mealy outputs: vend/change fire in the same cycle as the coin.
    // Reset dominates so a qualifying coin during reset never vends.
    always_comb begin
        newstate = S0;
        out      = 1'b0;
        chg      = 1'b0;
        if (!reset) begin
            unique case (state)
                S0: begin
                    unique case (coin)
                        COIN_5:  newstate = S5;
                        COIN_10: newstate = S10;
                        default: newstate = S0;
                    endcase
                end
                S5: begin
                    unique case (coin)
                        COIN_5:  newstate = S10;
                        COIN_10: begin
                            newstate = S0;
                            out      = 1'b1;
                        end
                        default: newstate = S5;
                    endcase
                end
                S10: begin
                    unique case (coin)
                        COIN_5: begin
                            newstate = S0;
                            out      = 1'b1;
                        end
                        COIN_10: begin
                            newstate = S0;
                            out      = 1'b1;
                            chg      = 1'b1;
                        end
                        default: newstate = S10;
                    endcase
                end
                // Upset into 2'b11: drop back to empty credit, no vend
                default: newstate = S0;
            endcase
        end
    end

`ifdef VENDING_MACHINE_CHANGE_RETURN_EN
    assign change = chg;
`else
    // Overpayment is absorbed when change return is not built
    logic unused_chg;
    assign unused_chg = chg;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine.
// Covers reset, vend paths, hold-repeat, idle/invalid coins, overpay.
module tb_vending_machine;

    logic       clk;
    logic       reset;
    logic [1:0] coin;
    logic       out;
    logic [1:0] state;
    logic [1:0] newstate;

    int compared   = 0;
    int mismatched = 0;

`ifdef VENDING_MACHINE_CHANGE_RETURN_EN
    logic change;
`endif

    vending_machine dut (
        .clk      (clk),
        .reset    (reset),
        .coin     (coin),
        .out      (out),
        .state    (state),
        .newstate (newstate)
`ifdef VENDING_MACHINE_CHANGE_RETURN_EN
        ,
        .change   (change)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check Mealy outputs mid-cycle,
    // then check the registered state just after the edge.
    task automatic cyc(input string tag, input logic r, input logic [1:0] c,
                       input logic eo, input logic [1:0] ens,
                       input logic ech);
        reset = r;
        coin  = c;
        #1;
        chk({tag, ".out"}, {1'b0, out}, {1'b0, eo});
        chk({tag, ".newstate"}, newstate, ens);
`ifdef VENDING_MACHINE_CHANGE_RETURN_EN
        chk({tag, ".change"}, {1'b0, change}, {1'b0, ech});
`else
        if (ech) begin
        end
`endif
        @(posedge clk);
        #1;
        chk({tag, ".state"}, state, ens);
    endtask

    initial begin
        reset = 1'b1;
        coin  = 2'b00;
        @(posedge clk);
        #1;

        cyc("rst_idle", 1'b1, 2'b00, 1'b0, 2'b00, 1'b0);

        cyc("to_s10",   1'b0, 2'b10, 1'b0, 2'b10, 1'b0);
        cyc("rst_s10c5", 1'b1, 2'b01, 1'b0, 2'b00, 1'b0);

        cyc("a_5",      1'b0, 2'b01, 1'b0, 2'b01, 1'b0);
        cyc("a_10",     1'b0, 2'b10, 1'b1, 2'b00, 1'b0);
        cyc("a_idle",   1'b0, 2'b00, 1'b0, 2'b00, 1'b0);

        cyc("b_10",     1'b0, 2'b10, 1'b0, 2'b10, 1'b0);
        cyc("b_5",      1'b0, 2'b01, 1'b1, 2'b00, 1'b0);

        for (int i = 0; i < 2; i++) begin
            cyc("h_5a", 1'b0, 2'b01, 1'b0, 2'b01, 1'b0);
            cyc("h_5b", 1'b0, 2'b01, 1'b0, 2'b10, 1'b0);
            cyc("h_5c", 1'b0, 2'b01, 1'b1, 2'b00, 1'b0);
        end

        cyc("s0_inv",   1'b0, 2'b11, 1'b0, 2'b00, 1'b0);

        cyc("i_5",      1'b0, 2'b01, 1'b0, 2'b01, 1'b0);
        cyc("i_none1",  1'b0, 2'b00, 1'b0, 2'b01, 1'b0);
        cyc("i_none2",  1'b0, 2'b00, 1'b0, 2'b01, 1'b0);
        cyc("i_inv1",   1'b0, 2'b11, 1'b0, 2'b01, 1'b0);
        cyc("i_inv2",   1'b0, 2'b11, 1'b0, 2'b01, 1'b0);
        cyc("rst_s5c10", 1'b1, 2'b10, 1'b0, 2'b00, 1'b0);

        cyc("o_10a",    1'b0, 2'b10, 1'b0, 2'b10, 1'b0);
        cyc("s10_inv",  1'b0, 2'b11, 1'b0, 2'b10, 1'b0);
        cyc("o_10b",    1'b0, 2'b10, 1'b1, 2'b00, 1'b1);

        cyc("r_10",     1'b0, 2'b10, 1'b0, 2'b10, 1'b0);
        cyc("rst_s10c10", 1'b1, 2'b10, 1'b0, 2'b00, 1'b0);
        cyc("post_rst", 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
